// File: rtl/led_shift_engine_pkg.sv
// Shared encodings for the LED shift engine: pattern modes and ping-pong FSM states.
package led_shift_engine_pkg;

  localparam int NB_MODE_DEF = 2;

  typedef enum logic [1:0] {
    MODE_ROT_L    = 2'b00,
    MODE_ROT_R    = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_FLASH    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_GO_LEFT  = 1'b0,
    ST_GO_RIGHT = 1'b1
  } state_e;

  // One-hot modes keep a single lit LED; flash toggles the whole bank.
  function automatic logic mode_is_onehot(input mode_e mode);
    return (mode != MODE_FLASH);
  endfunction

endpackage

// File: rtl/led_shift_engine_rise_edge_detect.sv
// Rising-edge detector for a level strobe; one pulse per low-to-high transition.
module rise_edge_detect (
  input  logic clk,
  input  logic i_ck_reset,
  input  logic i_level,
  output logic o_pulse
);

  logic level_r;

  // One-cycle delayed copy of the level, sampled every cycle.
  always_ff @(posedge clk or negedge i_ck_reset) begin
    if (!i_ck_reset) begin
      level_r <= 1'b0;
    end else begin
      level_r <= i_level;
    end
  end

  assign o_pulse = i_level & ~level_r;

endmodule

// File: rtl/led_shift_engine.sv
// LED pattern register advanced by prescaler strobes in rotate, ping-pong or flash mode.
module led_shift_engine
  import led_shift_engine_pkg::*;
#(
  parameter int NB_LEDS = 4,
  parameter int NB_MODE = NB_MODE_DEF
) (
  input  logic               clk,
  input  logic               i_ck_reset,
  input  logic               i_shift_enable,
  input  logic               i_run,
  input  logic [NB_MODE-1:0] i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_wrap
);

  localparam logic [NB_LEDS-1:0] SEED_ONEHOT = {{(NB_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NB_LEDS-1:0] ALL_ZERO    = {NB_LEDS{1'b0}};
  localparam logic [NB_LEDS-1:0] ALL_ONE     = {NB_LEDS{1'b1}};

  logic               step_s;
  logic               led_legal_s;
  logic [NB_MODE-1:0] mode_r;
  state_e             state_r;

  function automatic logic [NB_LEDS-1:0] mode_seed(input logic [NB_MODE-1:0] mode);
    if (mode_is_onehot(mode_e'(mode))) begin
      return SEED_ONEHOT;
    end else begin
      return ALL_ZERO;
    end
  endfunction

  rise_edge_detect u_edge (
    .clk        (clk),
    .i_ck_reset (i_ck_reset),
    .i_level    (i_shift_enable),
    .o_pulse    (step_s)
  );

  // A pattern the current mode could not have produced is replaced by the seed on the next step.
  always_comb begin
    led_legal_s = 1'b0;
    case (mode_e'(mode_r))
      MODE_ROT_L, MODE_ROT_R: begin
        led_legal_s = $onehot(o_led);
      end
      MODE_PINGPONG: begin
        if (state_r == ST_GO_LEFT) begin
          led_legal_s = $onehot(o_led) && !o_led[NB_LEDS-1];
        end else begin
          led_legal_s = $onehot(o_led) && !o_led[0];
        end
      end
      MODE_FLASH: begin
        led_legal_s = (o_led == ALL_ZERO) || (o_led == ALL_ONE);
      end
      default: begin
        led_legal_s = 1'b0;
      end
    endcase
  end

  // Pattern register, ping-pong FSM and wrap pulse; a mode change outranks any step.
  always_ff @(posedge clk or negedge i_ck_reset) begin
    if (!i_ck_reset) begin
      o_led   <= SEED_ONEHOT;
      o_wrap  <= 1'b0;
      state_r <= ST_GO_LEFT;
      mode_r  <= NB_MODE'(MODE_ROT_L);
    end else begin
      o_wrap <= 1'b0;
      if (i_mode != mode_r) begin
        mode_r  <= i_mode;
        o_led   <= mode_seed(i_mode);
        state_r <= ST_GO_LEFT;
      end else if (step_s && i_run) begin
        if (!led_legal_s) begin
          o_led   <= mode_seed(mode_r);
          state_r <= ST_GO_LEFT;
        end else begin
          case (mode_e'(mode_r))
            MODE_ROT_L: begin
              o_led  <= {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
              o_wrap <= o_led[NB_LEDS-1];
            end
            MODE_ROT_R: begin
              o_led  <= {o_led[0], o_led[NB_LEDS-1:1]};
              o_wrap <= o_led[0];
            end
            MODE_PINGPONG: begin
              if (state_r == ST_GO_LEFT) begin
                o_led <= {o_led[NB_LEDS-2:0], 1'b0};
                if (o_led[NB_LEDS-2]) begin
                  state_r <= ST_GO_RIGHT;
                  o_wrap  <= 1'b1;
                end else begin
                  state_r <= ST_GO_LEFT;
                end
              end else begin
                o_led <= {1'b0, o_led[NB_LEDS-1:1]};
                if (o_led[1]) begin
                  state_r <= ST_GO_LEFT;
                  o_wrap  <= 1'b1;
                end else begin
                  state_r <= ST_GO_RIGHT;
                end
              end
            end
            MODE_FLASH: begin
              o_led  <= ~o_led;
              o_wrap <= (o_led == ALL_ZERO);
            end
            default: begin
              o_led   <= mode_seed(mode_r);
              state_r <= ST_GO_LEFT;
            end
          endcase
        end
      end else begin
        o_led <= o_led;
      end
    end
  end

endmodule

// File: tb/tb_led_shift_engine.sv
// Directed bench for led_shift_engine: per-cycle model comparison plus literal checkpoints.
module tb_led_shift_engine;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         shift_en;
  logic         run;
  logic [1:0]   mode;
  logic [N-1:0] led;
  logic         wrap;

  int errors = 0;
  int checks = 0;

  // Model state: index of the lit LED, travel direction, flash phase.
  logic [1:0] m_mode;
  int         m_pos;
  logic       m_dir;
  logic       m_flash_on;
  logic       m_en_q;
  logic       m_wrap;

  led_shift_engine #(.NB_LEDS(N), .NB_MODE(2)) dut (
    .clk            (clk),
    .i_ck_reset     (rst_n),
    .i_shift_enable (shift_en),
    .i_run          (run),
    .i_mode         (mode),
    .o_led          (led),
    .o_wrap         (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_led();
    if (m_mode == 2'd3) begin
      return m_flash_on ? {N{1'b1}} : {N{1'b0}};
    end else begin
      return N'(1 << m_pos);
    end
  endfunction

  // Behavioural model advanced on the clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 2'd0; m_pos <= 0; m_dir <= 1'b0; m_flash_on <= 1'b0;
      m_en_q <= 1'b0; m_wrap <= 1'b0;
    end else begin
      m_en_q <= shift_en;
      m_wrap <= 1'b0;
      if (mode != m_mode) begin
        m_mode <= mode; m_pos <= 0; m_dir <= 1'b0; m_flash_on <= 1'b0;
      end else if (shift_en && !m_en_q && run) begin
        case (m_mode)
          2'd0: begin m_pos <= (m_pos + 1) % N;     m_wrap <= (m_pos == N - 1); end
          2'd1: begin m_pos <= (m_pos + N - 1) % N; m_wrap <= (m_pos == 0);     end
          2'd2: begin
            if (!m_dir) begin
              m_pos <= m_pos + 1;
              if (m_pos + 1 == N - 1) begin m_dir <= 1'b1; m_wrap <= 1'b1; end
            end else begin
              m_pos <= m_pos - 1;
              if (m_pos - 1 == 0) begin m_dir <= 1'b0; m_wrap <= 1'b1; end
            end
          end
          default: begin m_flash_on <= !m_flash_on; m_wrap <= !m_flash_on; end
        endcase
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    checks++;
    if (led !== model_led() || wrap !== m_wrap) begin
      errors++;
      $display("FAIL model t=%0t led=%b wrap=%b expected led=%b wrap=%b",
               $time, led, wrap, model_led(), m_wrap);
    end
  end

  task automatic check_lit(input string name, input logic [N-1:0] el, input logic ew);
    checks++;
    if (led !== el || wrap !== ew) begin
      errors++;
      $display("FAIL %s led=%b wrap=%b expected led=%b wrap=%b", name, led, wrap, el, ew);
    end
  endtask

  // Starts and ends aligned to a falling edge; checks the result of a single-cycle strobe.
  task automatic pulse(input string name, input logic [N-1:0] el, input logic ew);
    shift_en = 1'b1;
    @(negedge clk);
    shift_en = 1'b0;
    #1 check_lit(name, el, ew);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; shift_en = 1'b0; run = 1'b0; mode = 2'b00;
    repeat (2) @(negedge clk);
    #1 check_lit("reset", 4'b0001, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; run = 1'b1;
    @(negedge clk);

    // Rotate-left
    pulse("rotl1", 4'b0010, 1'b0);
    pulse("rotl2", 4'b0100, 1'b0);
    pulse("rotl3", 4'b1000, 1'b0);
    pulse("rotl4", 4'b0001, 1'b1);
    pulse("rotl5", 4'b0010, 1'b0);

    // Rotate-right with a long held strobe
    mode = 2'b01;
    @(negedge clk);
    #1 check_lit("rotr_reload", 4'b0001, 1'b0);
    shift_en = 1'b1;
    @(negedge clk);
    #1 check_lit("rotr_held", 4'b1000, 1'b1);
    repeat (19) @(negedge clk);
    shift_en = 1'b0;
    @(negedge clk);
    #1 check_lit("rotr_held_once", 4'b1000, 1'b0);
    pulse("rotr2", 4'b0100, 1'b0);
    pulse("rotr3", 4'b0010, 1'b0);
    pulse("rotr4", 4'b0001, 1'b0);

    // Ping-pong
    mode = 2'b10;
    @(negedge clk);
    pulse("pp1", 4'b0010, 1'b0);
    pulse("pp2", 4'b0100, 1'b0);
    pulse("pp3", 4'b1000, 1'b1);
    pulse("pp4", 4'b0100, 1'b0);
    pulse("pp5", 4'b0010, 1'b0);
    pulse("pp6", 4'b0001, 1'b1);
    pulse("pp7", 4'b0010, 1'b0);
    pulse("pp8", 4'b0100, 1'b0);

    // Flash
    mode = 2'b11;
    @(negedge clk);
    #1 check_lit("flash_reload", 4'b0000, 1'b0);
    @(negedge clk);
    pulse("flash1", 4'b1111, 1'b1);
    pulse("flash2", 4'b0000, 1'b0);
    pulse("flash3", 4'b1111, 1'b1);
    pulse("flash4", 4'b0000, 1'b0);

    // Mode change collides with a strobe
    mode = 2'b00;
    @(negedge clk);
    pulse("pre1", 4'b0010, 1'b0);
    pulse("pre2", 4'b0100, 1'b0);
    mode = 2'b10; shift_en = 1'b1;
    @(negedge clk);
    shift_en = 1'b0;
    #1 check_lit("mode_vs_step", 4'b0001, 1'b0);
    @(negedge clk);
    pulse("after_reload", 4'b0010, 1'b0);

    // Frozen while run is low
    run = 1'b0;
    pulse("frozen1", 4'b0010, 1'b0);
    pulse("frozen2", 4'b0010, 1'b0);
    pulse("frozen3", 4'b0010, 1'b0);
    run = 1'b1;
    pulse("resume", 4'b0100, 1'b0);

    // Asynchronous reset while the wrap pulse is high
    shift_en = 1'b1;
    @(posedge clk);
    #2 check_lit("pre_reset", 4'b1000, 1'b1);
    rst_n = 1'b0; mode = 2'b00;
    #1 check_lit("async_reset", 4'b0001, 1'b0);
    @(negedge clk);
    shift_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse("post_reset", 4'b0010, 1'b0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_shift_engine.md
Name: led_shift_engine

Overview:
- Consumer end of the shift-enable strobe produced by the board's prescaler counter.
- Drives the LED pattern register. Each rising edge of i_shift_enable advances the pattern by one step, in one of four modes chosen by switches.
- Sits between the prescaler and the board LEDs. One clock domain (clk, 100 MHz).

Parameters:
- NB_LEDS, 4, number of LEDs / pattern width; legal range is 2 or more.
- NB_MODE, 2, width of the mode selector; fixed by the encoding, not for override.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- i_ck_reset  input  1  asynchronous, active-low reset.
- i_shift_enable  input  1  step strobe from the prescaler; level may stay high for several cycles.
- i_run  input  1  1 = steps accepted, 0 = pattern frozen.
- i_mode  input  NB_MODE  00 rotate-left, 01 rotate-right, 10 ping-pong, 11 flash.
- o_led  output  NB_LEDS  current pattern.
- o_wrap  output  1  one-cycle pulse on end-of-sequence (defined below).

Behaviour:
- Reset (i_ck_reset=0, asynchronous):
  - o_led = seed, where seed = LSB one-hot (0001 for NB_LEDS=4).
  - o_wrap=0; ping-pong state=GO_LEFT; edge register=0; mode register=00.
- Edge detect:
  - step = i_shift_enable & ~enable_q, where enable_q is i_shift_enable registered every cycle regardless of i_run.
  - A level held high for N cycles produces exactly one step.
- Step acceptance:
  - A step is applied only if i_run=1.
  - A step arriving while i_run=0 is discarded, not queued.
- Latency: step detected at clock edge k gives o_led updated at edge k (visible from cycle k+1). There is no further pipeline.
- Mode change:
  - mode_q holds the registered i_mode.
  - When i_mode != mode_q: reload o_led to the mode seed, set ping-pong state=GO_LEFT, o_wrap=0, mode_q<=i_mode.
  - Reload has priority; a simultaneous step is dropped.
  - Seed is LSB one-hot for modes 00/01/10, and all-zeros for mode 11.
- Rotate-left: o_led <= {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]}. o_wrap=1 when the step moves the bit from the MSB to the LSB.
- Rotate-right: o_led <= {o_led[0], o_led[NB_LEDS-1:1]}. o_wrap=1 when the step moves the bit from the LSB to the MSB.
- Ping-pong FSM, states GO_LEFT and GO_RIGHT:
  - GO_LEFT: shift left by 1 (no rotate). If the result has the MSB set, go to GO_RIGHT and pulse o_wrap.
  - GO_RIGHT: shift right by 1. If the result has the LSB set, go to GO_LEFT and pulse o_wrap.
  - Never wraps around; the end LED is lit for exactly one step.
- Flash: o_led <= ~o_led. o_wrap=1 on each all-zeros to all-ones transition.
- o_wrap: a registered pulse, high for exactly one cycle, in the same cycle the new o_led appears; 0 otherwise.
- Illegal pattern recovery (e.g. SEU or all-zeros in a one-hot mode): the next step loads the seed instead of shifting.
- Reset asserted mid-sequence returns all state to reset values immediately. The first step after reset release operates from the seed.

Decomposition:
- Shared package holds:
  - mode encodings MODE_ROT_L=2'b00, MODE_ROT_R=2'b01, MODE_PINGPONG=2'b10, MODE_FLASH=2'b11;
  - FSM state encodings ST_GO_LEFT=1'b0, ST_GO_RIGHT=1'b1.
- One sub-module: rise_edge_detect (clk, i_ck_reset, i_level, o_pulse). The prescaler-side blocks reuse it too.

Test Plan:
- Reset, then mode=00, run=1, 5 single-cycle strobes -> o_led 0010,0100,1000,0001,0010; o_wrap high only on the 1000->0001 step.
- Mode=01, strobe held high 20 cycles, then 3 more pulses -> the held level gives 1 step (0001->1000, wrap=1), then 0100,0010,0001.
- Mode=10, 8 strobes -> 0010,0100,1000(wrap),0100,0010,0001(wrap),0010,0100; FSM toggles at the ends.
- Mode=11, 4 strobes -> 1111(wrap),0000,1111(wrap),0000.
- Mode switched 00->10 in the same cycle as a strobe, with o_led=0100 -> o_led=0001, state GO_LEFT, no wrap, strobe ignored. The next strobe gives 0010.
- run=0 with 3 strobes -> o_led unchanged. Assert reset mid-sequence (o_led=1000) -> o_led=0001 and o_wrap=0 immediately, without waiting for a clock edge.
